ahb_lite_sram_slave: RTL and testbench

- Parametrised AHB-Lite slave memory: word-addressed SRAM with byte/half/word (up to DATA_WIDTH) lane access and configurable wait states.
- Two-cycle ERROR response for illegal transfers.
- Sits behind the system address decoder (HSEL) and serves as the reference DUT target for the AHB-Lite UVM environment.
- Successor to the fixed 32-bit, zero-wait slave: generalised in data width, depth and latency, and adds a full error-response protocol.

---
 rtl/ahb_lite_sram_slave.sv | 161 ++++++++++++++++
 tb/tb_ahb_lite_sram_slave.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM slave: word-organised memory with byte-lane writes, optional wait
// states and a two-cycle ERROR response for out-of-range, oversized or misaligned transfers.
module ahb_lite_sram_slave #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic [1:0]            HRESP,
    output logic [DATA_WIDTH-1:0] HRDATA
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int LOG2B = $clog2(BYTES);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH + 1)'(DEPTH * BYTES);
    localparam logic [2:0] MAX_SIZE = 3'(LOG2B);
    localparam logic [2:0] OFF_MASK = 3'(BYTES - 1);
    localparam logic [3:0] WS       = 4'(WAIT_STATES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

    state_t                state_reg, state_next;
    logic [3:0]            cnt_reg, cnt_next;
    logic                  dp_valid_reg, dp_valid_next;
    logic                  dp_write_reg, dp_write_next;
    logic [IDX_W-1:0]      dp_idx_reg, dp_idx_next;
    logic [2:0]            dp_off_reg, dp_off_next;
    logic [2:0]            dp_size_reg, dp_size_next;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] mem_q_reg, fwd_data_reg, merged;
    logic [BYTES-1:0]      fwd_mask_reg, lane_en;

    logic                  ready_out, accept, addr_err, wr_commit;
    logic [2:0]            align_mask;
    logic [IDX_W-1:0]      a_idx, rd_idx;
    logic                  unused_ok;

    assign unused_ok = &{1'b0, HBURST, HTRANS[0]};

    assign ready_out = (state_reg == S_IDLE) || (state_reg == S_ERR2);
    assign accept    = HSEL && HREADY && HTRANS[1] && ready_out;
    assign a_idx     = HADDR[LOG2B +: IDX_W];

    always_comb begin
        align_mask = 3'b111;
        case (HSIZE)
            3'd0:    align_mask = 3'b000;
            3'd1:    align_mask = 3'b001;
            3'd2:    align_mask = 3'b011;
            default: align_mask = 3'b111;
        endcase
    end

    assign addr_err = ({1'b0, HADDR} >= MEM_BYTES) || (HSIZE > MAX_SIZE)
                      || (|(HADDR[2:0] & align_mask));

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_reg    <= S_IDLE;
            cnt_reg      <= 4'd0;
            dp_valid_reg <= 1'b0;
            dp_write_reg <= 1'b0;
            dp_idx_reg   <= '0;
            dp_off_reg   <= 3'd0;
            dp_size_reg  <= 3'd0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            dp_valid_reg <= dp_valid_next;
            dp_write_reg <= dp_write_next;
            dp_idx_reg   <= dp_idx_next;
            dp_off_reg   <= dp_off_next;
            dp_size_reg  <= dp_size_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        dp_valid_next = dp_valid_reg;
        dp_write_next = dp_write_reg;
        dp_idx_next   = dp_idx_reg;
        dp_off_next   = dp_off_reg;
        dp_size_next  = dp_size_reg;
        case (state_reg)
            S_WAIT: begin
                cnt_next = cnt_reg - 4'd1;
                if (cnt_reg <= 4'd1) state_next = S_IDLE;
            end
            S_ERR1: state_next = S_ERR2;
            default: begin
                // IDLE and ERR2 both end the current data phase this cycle
                state_next    = S_IDLE;
                dp_valid_next = 1'b0;
                if (accept) begin
                    dp_write_next = HWRITE;
                    dp_idx_next   = a_idx;
                    dp_off_next   = HADDR[2:0] & OFF_MASK;
                    dp_size_next  = HSIZE;
                    if (addr_err) begin
                        state_next = S_ERR1;
                    end else begin
                        dp_valid_next = 1'b1;
                        if (WS != 4'd0) begin
                            state_next = S_WAIT;
                            cnt_next   = WS;
                        end
                    end
                end
            end
        endcase
    end

    assign wr_commit = ready_out && dp_valid_reg && dp_write_reg && !HRESET;
    assign rd_idx    = accept ? a_idx : dp_idx_reg;

    genvar gi;
    generate
        for (gi = 0; gi < BYTES; gi++) begin : g_lane
            localparam logic [2:0] LANE = 3'(gi);
            assign lane_en[gi] = ((LANE ^ dp_off_reg) >> dp_size_reg) == 3'd0;
            assign merged[gi*8 +: 8] = fwd_mask_reg[gi] ? fwd_data_reg[gi*8 +: 8]
                                                        : mem_q_reg[gi*8 +: 8];
        end
    endgenerate

    always_ff @(posedge HCLK) begin
        if (wr_commit) begin
            for (int b = 0; b < BYTES; b++) begin
                if (lane_en[b]) mem[dp_idx_reg][b*8 +: 8] <= HWDATA[b*8 +: 8];
            end
        end
        mem_q_reg <= mem[rd_idx];
    end

    // Same-edge write bypass: the registered read above sees the pre-write word
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            fwd_mask_reg <= '0;
        end else begin
            fwd_mask_reg <= (wr_commit && (rd_idx == dp_idx_reg)) ? lane_en : '0;
        end
        fwd_data_reg <= HWDATA;
    end

    assign HREADYOUT = ready_out;
    assign HRESP     = ((state_reg == S_ERR1) || (state_reg == S_ERR2)) ? 2'b01 : 2'b00;
    assign HRDATA    = (state_reg == S_IDLE && dp_valid_reg && !dp_write_reg) ? merged : '0;
endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Bench for ahb_lite_sram_slave: three instances (0, 3 and 2 wait states) on a shared
// bus, a table of transfers, and a negedge monitor popping an expectation queue.
module tb_ahb_lite_sram_slave;
    localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NS = 2'b10, T_SEQ = 2'b11;
    localparam logic [1:0] OK = 2'b00, ERR = 2'b01;

    typedef struct {
        string       name;
        logic        wr;
        logic [1:0]  trans;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } vec_t;

    typedef struct {
        string       name;
        logic        wr;
        logic [1:0]  resp;
        logic [31:0] rdata;
        int          waits;
    } exp_t;

    logic        clk = 1'b0;
    logic        hreset = 1'b1;
    logic        sel_v = 1'b0;
    logic        force_lo = 1'b0;
    logic [1:0]  act = 2'd0;
    logic [31:0] haddr = '0;
    logic [1:0]  htrans = T_IDLE;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = 3'd2;
    logic [2:0]  hburst = 3'd0;
    logic [31:0] hwdata = '0;
    logic        hready;
    logic        ro [3];
    logic [1:0]  rs [3];
    logic [31:0] rd [3];

    int   total = 0;
    int   bad = 0;
    int   mon_waits = 0;
    exp_t exp_q[$];
    exp_t e;
    vec_t tbl[$];

    always #5 clk = ~clk;

    assign hready = force_lo ? 1'b0 : ro[act];

    ahb_lite_sram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(256), .WAIT_STATES(0)) u0 (
        .HCLK(clk), .HRESET(hreset), .HSEL(sel_v && act == 2'd0), .HADDR(haddr),
        .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
        .HREADY(hready), .HREADYOUT(ro[0]), .HRESP(rs[0]), .HRDATA(rd[0]));
    ahb_lite_sram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(256), .WAIT_STATES(3)) u3 (
        .HCLK(clk), .HRESET(hreset), .HSEL(sel_v && act == 2'd1), .HADDR(haddr),
        .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
        .HREADY(hready), .HREADYOUT(ro[1]), .HRESP(rs[1]), .HRDATA(rd[1]));
    ahb_lite_sram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(256), .WAIT_STATES(2)) u2 (
        .HCLK(clk), .HRESET(hreset), .HSEL(sel_v && act == 2'd2), .HADDR(haddr),
        .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
        .HREADY(hready), .HREADYOUT(ro[2]), .HRESP(rs[2]), .HRDATA(rd[2]));

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic vec_t mk(input string nm, input logic wr, input logic [1:0] tr,
                                input logic [31:0] a, input logic [2:0] sz,
                                input logic [31:0] wd, input logic [1:0] rsp,
                                input logic [31:0] rdv);
        vec_t v;
        v.name = nm; v.wr = wr; v.trans = tr; v.addr = a; v.size = sz;
        v.wdata = wd; v.resp = rsp; v.rdata = rdv;
        return v;
    endfunction

    function automatic int ws_of(input logic [1:0] k);
        return (k == 2'd0) ? 0 : (k == 2'd1) ? 3 : 2;
    endfunction

    // Present one address phase (called at posedge+1), wait for acceptance, queue expectation
    task automatic issue(input vec_t v);
        int   n;
        exp_t x;
        sel_v = 1'b1; htrans = v.trans; hwrite = v.wr; haddr = v.addr; hsize = v.size;
        hburst = (v.trans == T_SEQ) ? 3'b011 : 3'b000;
        n = 0;
        while (!hready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            total++; bad++;
            $display("FAIL %s_accept_timeout: got hready=0 expected 1", v.name);
        end
        @(posedge clk); #1;
        x.name = v.name; x.wr = v.wr; x.resp = v.resp; x.rdata = v.rdata;
        x.waits = (v.resp == ERR) ? 1 : ws_of(act);
        exp_q.push_back(x);
        if (v.wr) hwdata = v.wdata;
        sel_v = 1'b0; htrans = T_IDLE;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() > 0) begin
            total++; bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    always @(negedge clk) begin
        if (!hreset) begin
            if (exp_q.size() == 0) begin
                chk("idle_ready", 32'(ro[act]), 32'd1);
                chk("idle_resp", 32'(rs[act]), 32'(OK));
            end else if (!ro[act]) begin
                mon_waits++;
                chk({exp_q[0].name, "_wait_resp"}, 32'(rs[act]), 32'(exp_q[0].resp));
                chk({exp_q[0].name, "_wait_rdata"}, rd[act], 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk({e.name, "_resp"}, 32'(rs[act]), 32'(e.resp));
                chk({e.name, "_waits"}, 32'(mon_waits), 32'(e.waits));
                if (!e.wr && e.resp == OK) chk({e.name, "_rdata"}, rd[act], e.rdata);
                if (e.resp == ERR) chk({e.name, "_err_rdata"}, rd[act], 32'd0);
                $display("txn %s dut=%0d wr=%0d resp=%0d rdata=%h waits=%0d",
                         e.name, act, e.wr, rs[act], rd[act], mon_waits);
                mon_waits = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl.push_back(mk("w00",        1, T_NS,  32'h000, 3'd2, 32'h01020304, OK,  32'h0));
        tbl.push_back(mk("w10",        1, T_NS,  32'h010, 3'd2, 32'hDEADBEEF, OK,  32'h0));
        tbl.push_back(mk("r10_fwd",    0, T_NS,  32'h010, 3'd2, 32'h0,        OK,  32'hDEADBEEF));
        tbl.push_back(mk("w20",        1, T_NS,  32'h020, 3'd2, 32'hA0A00020, OK,  32'h0));
        tbl.push_back(mk("w24",        1, T_SEQ, 32'h024, 3'd2, 32'hA0A00024, OK,  32'h0));
        tbl.push_back(mk("w28",        1, T_SEQ, 32'h028, 3'd2, 32'hA0A00028, OK,  32'h0));
        tbl.push_back(mk("w2c",        1, T_SEQ, 32'h02C, 3'd2, 32'hA0A0002C, OK,  32'h0));
        tbl.push_back(mk("r20",        0, T_NS,  32'h020, 3'd2, 32'h0,        OK,  32'hA0A00020));
        tbl.push_back(mk("r24",        0, T_SEQ, 32'h024, 3'd2, 32'h0,        OK,  32'hA0A00024));
        tbl.push_back(mk("r28",        0, T_SEQ, 32'h028, 3'd2, 32'h0,        OK,  32'hA0A00028));
        tbl.push_back(mk("r2c",        0, T_SEQ, 32'h02C, 3'd2, 32'h0,        OK,  32'hA0A0002C));
        tbl.push_back(mk("w40",        1, T_NS,  32'h040, 3'd2, 32'h11223344, OK,  32'h0));
        tbl.push_back(mk("wb41",       1, T_NS,  32'h041, 3'd0, 32'hAAAAAAAA, OK,  32'h0));
        tbl.push_back(mk("wh42",       1, T_NS,  32'h042, 3'd1, 32'hBEEFBEEF, OK,  32'h0));
        tbl.push_back(mk("r40",        0, T_NS,  32'h040, 3'd2, 32'h0,        OK,  32'hBEEFAA44));
        tbl.push_back(mk("rb43",       0, T_NS,  32'h043, 3'd0, 32'h0,        OK,  32'hBEEFAA44));
        tbl.push_back(mk("w3fc_last",  1, T_NS,  32'h3FC, 3'd2, 32'h5A5A5A5A, OK,  32'h0));
        tbl.push_back(mk("r3fc_last",  0, T_NS,  32'h3FC, 3'd2, 32'h0,        OK,  32'h5A5A5A5A));
        tbl.push_back(mk("werr_range", 1, T_NS,  32'h400, 3'd2, 32'hFFFFFFFF, ERR, 32'h0));
        tbl.push_back(mk("rerr_misal", 0, T_NS,  32'h002, 3'd2, 32'h0,        ERR, 32'h0));
        tbl.push_back(mk("rerr_size",  0, T_NS,  32'h000, 3'd3, 32'h0,        ERR, 32'h0));
        tbl.push_back(mk("r10_in_err2",0, T_NS,  32'h010, 3'd2, 32'h0,        OK,  32'hDEADBEEF));
        tbl.push_back(mk("werr_half",  1, T_NS,  32'h041, 3'd1, 32'h12341234, ERR, 32'h0));
        tbl.push_back(mk("r00_kept",   0, T_NS,  32'h000, 3'd2, 32'h0,        OK,  32'h01020304));
        tbl.push_back(mk("r40_kept",   0, T_NS,  32'h040, 3'd2, 32'h0,        OK,  32'hBEEFAA44));

        // Reset: two cycles, outputs checked while still in reset
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_ready%0d", k), 32'(ro[k]), 32'd1);
            chk($sformatf("rst_resp%0d", k), 32'(rs[k]), 32'(OK));
            chk($sformatf("rst_rdata%0d", k), rd[k], 32'd0);
        end
        @(posedge clk); #1;
        hreset = 1'b0;

        // IDLE and BUSY while selected: no transfer, monitor expects ready OKAY
        act = 2'd0; sel_v = 1'b1; htrans = T_BUSY; haddr = 32'h10; hwrite = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        htrans = T_IDLE;
        repeat (2) begin @(posedge clk); #1; end
        sel_v = 1'b0;

        foreach (tbl[i]) issue(tbl[i]);
        drain();

        // HREADY held low by another slave: a NONSEQ write must not be taken
        force_lo = 1'b1; sel_v = 1'b1; htrans = T_NS; hwrite = 1'b1; haddr = 32'h10;
        hsize = 3'd2; hwdata = 32'h0;
        repeat (3) begin @(posedge clk); #1; end
        htrans = T_IDLE; sel_v = 1'b0; force_lo = 1'b0;
        issue(mk("r10_hready_lo", 0, T_NS, 32'h010, 3'd2, 32'h0, OK, 32'hDEADBEEF));
        drain();

        // Three wait states, errors skip them
        act = 2'd1;
        issue(mk("ws3_w08",   1, T_NS, 32'h008, 3'd2, 32'hCAFEF00D, OK,  32'h0));
        issue(mk("ws3_r08",   0, T_NS, 32'h008, 3'd2, 32'h0,        OK,  32'hCAFEF00D));
        issue(mk("ws3_err",   1, T_NS, 32'h500, 3'd2, 32'h0,        ERR, 32'h0));
        issue(mk("ws3_rb09",  0, T_NS, 32'h009, 3'd0, 32'h0,        OK,  32'hCAFEF00D));
        drain();

        // Reset during a wait cycle of a write: the write is dropped
        act = 2'd2;
        issue(mk("ws2_w80",   1, T_NS, 32'h080, 3'd2, 32'h12345678, OK, 32'h0));
        issue(mk("ws2_r80",   0, T_NS, 32'h080, 3'd2, 32'h0,        OK, 32'h12345678));
        drain();
        issue(mk("ws2_w80_rst", 1, T_NS, 32'h080, 3'd2, 32'h00000055, OK, 32'h0));
        hreset = 1'b1;
        @(posedge clk); #1;
        exp_q.delete();
        mon_waits = 0;
        hreset = 1'b0;
        chk("midrst_ready", 32'(ro[2]), 32'd1);
        chk("midrst_resp", 32'(rs[2]), 32'(OK));
        chk("midrst_rdata", rd[2], 32'd0);
        issue(mk("ws2_r80_kept", 0, T_NS, 32'h080, 3'd2, 32'h0, OK, 32'h12345678));
        drain();

        @(posedge clk); #1;
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
